// File: rtl/bias_loader_pkg.sv
// rtl/bias_loader_pkg.sv - shared state encoding and constants for the bias loader
package bias_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FETCH,
    HOLD
  } bias_ld_state_e;

  localparam int BIAS_WORD_BYTES = 4;

endpackage

// File: rtl/bias_loader_icb_rd_seq.sv
// rtl/bias_loader_icb_rd_seq.sv - ICB read command/response counter pair
// Issues N in-order reads while granted and tracks responses against them.
module bias_loader_icb_rd_seq #(
  parameter int N     = 16,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active,
  input  logic             granted,
  input  logic             cmd_ready,
  input  logic             rsp_valid,
  output logic             cmd_valid,
  output logic             rsp_ready,
  output logic             rsp_fire,
  output logic             rsp_last,
  output logic [CNT_W-1:0] cmd_cnt,
  output logic [CNT_W-1:0] rsp_cnt
);

  logic [CNT_W-1:0] cmd_cnt_q, cmd_cnt_d;
  logic [CNT_W-1:0] rsp_cnt_q, rsp_cnt_d;
  logic             cmd_fire;

  always_comb begin
    cmd_valid = active && granted && (cmd_cnt_q < CNT_W'(N));
    rsp_ready = active;
    cmd_fire  = cmd_valid && cmd_ready;
    // A response is only counted while a command is outstanding.
    rsp_fire  = rsp_valid && rsp_ready && (rsp_cnt_q != cmd_cnt_q);
    rsp_last  = rsp_fire && (rsp_cnt_q == CNT_W'(N - 1));
    cmd_cnt_d = cmd_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    if (!active || rsp_last) begin
      cmd_cnt_d = '0;
      rsp_cnt_d = '0;
    end else begin
      if (cmd_fire) cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
      if (rsp_fire) rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_cnt_q <= '0;
      rsp_cnt_q <= '0;
    end else begin
      cmd_cnt_q <= cmd_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
    end
  end

  assign cmd_cnt = cmd_cnt_q;
  assign rsp_cnt = rsp_cnt_q;

endmodule

// File: rtl/bias_loader.sv
// rtl/bias_loader.sv - requests the ICB bus, fetches one bias vector per tile
// and holds it for the accumulator until the tile is consumed.
module bias_loader
  import bias_loader_pkg::*;
#(
  parameter int SIZE       = 16,
  parameter int BUS_WIDTH  = 32,
  parameter int REG_WIDTH  = 32,
  parameter int BIAS_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       init_cfg_bias,
  input  logic [REG_WIDTH-1:0]       cfg_bias_base_addr,
  input  logic [REG_WIDTH-1:0]       cfg_tile_num,
  output logic                       load_bias_req,
  input  logic                       load_bias_granted,
  input  logic                       tile_calc_over,
  output logic                       bias_valid,
  output logic [SIZE*BIAS_WIDTH-1:0] bias_data,
  output logic                       bias_err,
  output logic                       layer_done,
  output logic                       icb_cmd_valid,
  input  logic                       icb_cmd_ready,
  output logic [REG_WIDTH-1:0]       icb_cmd_addr,
  output logic                       icb_cmd_read,
  output logic [BUS_WIDTH-1:0]       icb_cmd_wdata,
  output logic [BUS_WIDTH/8-1:0]     icb_cmd_wmask,
  input  logic                       icb_rsp_valid,
  output logic                       icb_rsp_ready,
  input  logic [BUS_WIDTH-1:0]       icb_rsp_rdata,
  input  logic                       icb_rsp_err
);

  localparam int CNT_W = $clog2(SIZE) + 1;

  bias_ld_state_e             state_q, state_d;
  logic [REG_WIDTH-1:0]       base_q, base_d;
  logic [REG_WIDTH-1:0]       tiles_q, tiles_d;
  logic [REG_WIDTH-1:0]       tile_idx_q, tile_idx_d;
  logic                       req_q, req_d;
  logic                       valid_q, valid_d;
  logic                       err_q, err_d;
  logic                       done_q, done_d;
  logic [SIZE*BIAS_WIDTH-1:0] data_q, data_d;
  logic                       rsp_fire, rsp_last;
  logic [CNT_W-1:0]           cmd_cnt, rsp_cnt;

  bias_loader_icb_rd_seq #(
    .N    (SIZE),
    .CNT_W(CNT_W)
  ) u_rd_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .active   (state_q == FETCH),
    .granted  (load_bias_granted),
    .cmd_ready(icb_cmd_ready),
    .rsp_valid(icb_rsp_valid),
    .cmd_valid(icb_cmd_valid),
    .rsp_ready(icb_rsp_ready),
    .rsp_fire (rsp_fire),
    .rsp_last (rsp_last),
    .cmd_cnt  (cmd_cnt),
    .rsp_cnt  (rsp_cnt)
  );

  // Word address wraps modulo 2^REG_WIDTH by construction.
  assign icb_cmd_addr = base_q + (tile_idx_q * REG_WIDTH'(SIZE) + REG_WIDTH'(cmd_cnt))
                        * REG_WIDTH'(BIAS_WORD_BYTES);
  assign icb_cmd_read  = 1'b1;
  assign icb_cmd_wdata = '0;
  assign icb_cmd_wmask = '0;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    tiles_d    = tiles_q;
    tile_idx_d = tile_idx_q;
    req_d      = req_q;
    valid_d    = valid_q;
    err_d      = err_q;
    done_d     = 1'b0;
    data_d     = data_q;
    case (state_q)
      IDLE: begin
        if (init_cfg_bias) begin
          base_d     = cfg_bias_base_addr;
          tiles_d    = cfg_tile_num;
          tile_idx_d = '0;
          err_d      = 1'b0;
          if (cfg_tile_num == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
          end
        end
      end
      REQ: begin
        if (load_bias_granted) state_d = FETCH;
      end
      FETCH: begin
        if (rsp_fire) begin
          for (int i = 0; i < SIZE; i++) begin
            if (rsp_cnt == CNT_W'(i)) data_d[i*BIAS_WIDTH +: BIAS_WIDTH] = icb_rsp_rdata;
          end
          if (icb_rsp_err) err_d = 1'b1;
        end
        if (rsp_last) begin
          state_d = HOLD;
          req_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (tile_calc_over) begin
          valid_d    = 1'b0;
          tile_idx_d = tile_idx_q + REG_WIDTH'(1);
          if (tile_idx_q + REG_WIDTH'(1) == tiles_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      tiles_q    <= '0;
      tile_idx_q <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      tiles_q    <= tiles_d;
      tile_idx_q <= tile_idx_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      done_q     <= done_d;
      data_q     <= data_d;
    end
  end

  assign load_bias_req = req_q;
  assign bias_valid    = valid_q;
  assign bias_err      = err_q;
  assign layer_done    = done_q;
  assign bias_data     = data_q;

endmodule
